// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_hold_counter.sv
// Saturating count of CPU grants made while DMA waits; at_max forces a DMA turn.
module arb_hold_counter #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment so a DMA grant always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q != MaxHold)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxHold);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU has priority, DMA is guaranteed a turn after MAX_HOLD CPU grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [AWIDTH-1:0] cpu_addr_i,
  input  logic [DWIDTH-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_done_o,
  output logic [DWIDTH-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_wr_i,
  input  logic [AWIDTH-1:0] dma_addr_i,
  input  logic [DWIDTH-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_done_o,
  output logic [DWIDTH-1:0] dma_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [3:0] LastLat = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [3:0]        lat_q, lat_d;
  logic              cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d, dma_done_q, dma_done_d;
  logic [DWIDTH-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic              hold_inc, hold_clr, hold_at_max;

  arb_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (hold_inc),
    .clr_i    (hold_clr),
    .at_max_o (hold_at_max)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    lat_d       = lat_q;
    cpu_gnt_d   = 1'b0;
    dma_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    hold_inc    = 1'b0;
    hold_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        lat_d = 4'd0;
        if (!dma_req_i) hold_clr = 1'b1;
        if (dma_req_i && (!cpu_req_i || hold_at_max)) begin
          owner_d   = OWN_DMA;
          addr_d    = dma_addr_i;
          wdata_d   = dma_wdata_i;
          wr_d      = dma_wr_i;
          dma_gnt_d = 1'b1;
          mem_rd_d  = !dma_wr_i;
          mem_wr_d  = dma_wr_i;
          hold_clr  = 1'b1;
          state_d   = ACCESS;
        end else if (cpu_req_i) begin
          owner_d   = OWN_CPU;
          addr_d    = cpu_addr_i;
          wdata_d   = cpu_wdata_i;
          wr_d      = cpu_wr_i;
          cpu_gnt_d = 1'b1;
          mem_rd_d  = !cpu_wr_i;
          mem_wr_d  = cpu_wr_i;
          hold_inc  = dma_req_i;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is only guaranteed in the final strobe cycle, so capture there.
        if (lat_q == LastLat) begin
          lat_d   = 4'd0;
          state_d = DONE;
          if (owner_q == OWN_DMA) begin
            dma_done_d = 1'b1;
            if (!wr_q) dma_rdata_d = mem_rdata_i;
          end else begin
            cpu_done_d = 1'b1;
            if (!wr_q) cpu_rdata_d = mem_rdata_i;
          end
        end else begin
          lat_d    = lat_q + 4'd1;
          mem_rd_d = mem_rd_q;
          mem_wr_d = mem_wr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      lat_q       <= 4'd0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      lat_q       <= lat_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign cpu_gnt_o   = cpu_gnt_q;
  assign dma_gnt_o   = dma_gnt_q;
  assign cpu_done_o  = cpu_done_q;
  assign dma_done_o  = dma_done_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = (state_q == ACCESS) ? addr_q : '0;
  assign mem_wdata_o = (state_q == ACCESS) ? wdata_q : '0;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3 share all inputs.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cpuReq, cpuWr, dmaReq, dmaWr;
  logic [AW-1:0] cpuAddr, dmaAddr;
  logic [DW-1:0] cpuWdata, dmaWdata;

  logic          cpuGnt1, cpuDone1, dmaGnt1, dmaDone1, memRd1, memWr1, busy1;
  logic [DW-1:0] cpuRdata1, dmaRdata1, memWdata1, memRdata1;
  logic [AW-1:0] memAddr1;
  logic          cpuGnt3, cpuDone3, dmaGnt3, dmaDone3, memRd3, memWr3, busy3;
  logic [DW-1:0] cpuRdata3, dmaRdata3, memWdata3, memRdata3;
  logic [AW-1:0] memAddr3;

  logic [DW-1:0] tbMem [0:31];

  int totalChecks = 0;
  int badChecks   = 0;

  assign memRdata1 = tbMem[memAddr1];
  assign memRdata3 = tbMem[memAddr3];

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(1), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .cpu_req_i(cpuReq), .cpu_wr_i(cpuWr), .cpu_addr_i(cpuAddr), .cpu_wdata_i(cpuWdata),
    .cpu_gnt_o(cpuGnt1), .cpu_done_o(cpuDone1), .cpu_rdata_o(cpuRdata1),
    .dma_req_i(dmaReq), .dma_wr_i(dmaWr), .dma_addr_i(dmaAddr), .dma_wdata_i(dmaWdata),
    .dma_gnt_o(dmaGnt1), .dma_done_o(dmaDone1), .dma_rdata_o(dmaRdata1),
    .mem_addr_o(memAddr1), .mem_wdata_o(memWdata1), .mem_rd_o(memRd1), .mem_wr_o(memWr1),
    .mem_rdata_i(memRdata1), .busy_o(busy1)
  );

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(3), .MAX_HOLD(4)) dutLat3 (
    .clk_i(clk), .rst_ni(rstN),
    .cpu_req_i(cpuReq), .cpu_wr_i(cpuWr), .cpu_addr_i(cpuAddr), .cpu_wdata_i(cpuWdata),
    .cpu_gnt_o(cpuGnt3), .cpu_done_o(cpuDone3), .cpu_rdata_o(cpuRdata3),
    .dma_req_i(dmaReq), .dma_wr_i(dmaWr), .dma_addr_i(dmaAddr), .dma_wdata_i(dmaWdata),
    .dma_gnt_o(dmaGnt3), .dma_done_o(dmaDone3), .dma_rdata_o(dmaRdata3),
    .mem_addr_o(memAddr3), .mem_wdata_o(memWdata3), .mem_rd_o(memRd3), .mem_wr_o(memWr3),
    .mem_rdata_i(memRdata3), .busy_o(busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWr, input logic [AW-1:0] cAddr,
                               input logic [DW-1:0] cWdata, input logic dReq, input logic dWr,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    cpuReq = cReq; cpuWr = cWr; cpuAddr = cAddr; cpuWdata = cWdata;
    dmaReq = dReq; dmaWr = dWr; dmaAddr = dAddr; dmaWdata = dWdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns which port was granted next (0=CPU, 1=DMA, -1=none) and how many cycles that took.
  task automatic waitGrant(output int who, output int cycles);
    who = -1;
    cycles = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (cpuGnt1 || dmaGnt1) begin
        who = dmaGnt1 ? 1 : 0;
        cycles = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation ran past time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int who, cycles, strobeCnt, doneAt;
    logic seen;
    int expOrder [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    for (int i = 0; i < 32; i++) tbMem[i] = 8'(i) ^ 8'h40;
    tbMem[3] = 8'hA5;
    tbMem[5] = 8'h5A;

    // Reset held with a pending CPU request: everything must stay quiet.
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    #12;
    checkOutput("rstCtrl", {25'd0, cpuGnt1, cpuDone1, dmaGnt1, dmaDone1, memRd1, memWr1, busy1}, 32'h0);
    checkOutput("rstData", {3'd0, memAddr1, memWdata1, cpuRdata1, dmaRdata1}, 32'h0);
    #18;
    rstN = 1'b1;
    tick();
    checkOutput("rstFirstGnt", {31'd0, cpuGnt1}, 32'h1);
    tick();
    checkOutput("rstFirstDone", {31'd0, cpuDone1}, 32'h1);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    repeat (6) tick();

    $display("[TB] CPU read");
    applyStimulus(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    checkOutput("cpuRdGnt", {28'd0, cpuGnt1, memRd1, memWr1, busy1}, 32'b1101);
    checkOutput("cpuRdAddr", {27'd0, memAddr1}, 32'h03);
    checkOutput("cpuRdDmaQuiet", {30'd0, dmaGnt1, dmaDone1}, 32'h0);
    tick();
    checkOutput("cpuRdDone", {29'd0, cpuDone1, cpuGnt1, memRd1}, 32'b100);
    checkOutput("cpuRdData", {24'd0, cpuRdata1}, 32'hA5);
    checkOutput("cpuRdDmaHold", {22'd0, dmaGnt1, dmaDone1, dmaRdata1}, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    checkOutput("idleAfterRd", {18'd0, busy1, memAddr1, memWdata1}, 32'h0);

    $display("[TB] CPU write keeps rdata");
    applyStimulus(1'b1, 1'b1, 5'h07, 8'hE1, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    checkOutput("cpuWrStrobe", {16'd0, memRd1, memWr1, 1'b0, memAddr1, memWdata1}, {16'd0, 1'b0, 1'b1, 1'b0, 5'h07, 8'hE1});
    tick();
    checkOutput("cpuWrDone", {23'd0, cpuDone1, cpuRdata1}, {23'd0, 1'b1, 8'hA5});
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();

    $display("[TB] DMA read then DMA write");
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h05, 8'h00);
    tick();
    checkOutput("dmaRdGnt", {29'd0, dmaGnt1, cpuGnt1, memRd1}, 32'b101);
    tick();
    checkOutput("dmaRdDone", {15'd0, dmaDone1, cpuDone1, dmaRdata1, cpuRdata1}, {15'd0, 1'b1, 1'b0, 8'h5A, 8'hA5});
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h1F, 8'h3C);
    tick();
    checkOutput("dmaWrStrobe", {15'd0, dmaGnt1, cpuGnt1, memRd1, memWr1, memAddr1, memWdata1},
                {15'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h1F, 8'h3C});
    tick();
    checkOutput("dmaWrDone", {22'd0, dmaDone1, memWr1, dmaRdata1}, {22'd0, 1'b1, 1'b0, 8'h5A});
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    checkOutput("idleAfterWr", {18'd0, busy1, memAddr1, memWdata1}, 32'h0);

    $display("[TB] contention");
    applyStimulus(1'b1, 1'b0, 5'h01, 8'h00, 1'b1, 1'b0, 5'h02, 8'h00);
    for (int g = 0; g < 10; g++) begin
      waitGrant(who, cycles);
      checkOutput($sformatf("grantOrder%0d", g), 32'(who), 32'(expOrder[g]));
      checkOutput($sformatf("grantGap%0d", g), 32'(cycles), (g == 0) ? 32'd1 : 32'd3);
    end
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    repeat (4) tick();

    $display("[TB] withdrawn CPU request");
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h05, 8'h00);
    tick();
    checkOutput("wdDmaGnt", {31'd0, dmaGnt1}, 32'h1);
    applyStimulus(1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h05, 8'h00);
    tick();
    checkOutput("wdDmaDone", {31'd0, dmaDone1}, 32'h1);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | cpuGnt1 | dmaGnt1 | busy1;
    end
    checkOutput("wdStaysIdle", {31'd0, seen}, 32'h0);
    repeat (6) tick();

    $display("[TB] MEM_LAT=3 read");
    applyStimulus(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    strobeCnt = 0;
    doneAt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) checkOutput("lat3Gnt", {31'd0, cpuGnt3}, 32'h1);
      if (memRd3) strobeCnt++;
      if (cpuDone3) begin
        doneAt = c;
        checkOutput("lat3Data", {24'd0, cpuRdata3}, 32'hA5);
        applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
        break;
      end
    end
    checkOutput("lat3Strobes", 32'(strobeCnt), 32'd3);
    checkOutput("lat3DoneAt", 32'(doneAt), 32'd4);
    repeat (6) tick();

    $display("[TB] reset mid-access");
    applyStimulus(1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    tick();
    checkOutput("midBeforeRst", {30'd0, memRd3, busy3}, 32'b11);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midAsyncDrop", {26'd0, memRd3, memWr3, busy3, cpuDone3, cpuGnt3, 1'b0}, 32'h0);
    checkOutput("midRdataClr", {19'd0, memAddr3, cpuRdata3}, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    #10;
    rstN = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | cpuDone3 | busy3;
    end
    checkOutput("midNoDone", {31'd0, seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single instruction/data memory between two requesters.
- Requester one is the CPU controller's fetch/load/store port. Requester two is a DMA/program-loader port used to fill memory before and between runs.
- Sits between those two ports and the memory, and sequences every access: arbitration, fixed-latency access window, completion pulse.
- CPU has priority. A hold counter bounds DMA starvation.

Parameters:
- AWIDTH, 5, memory address width.
- DWIDTH, 8, memory data width.
- MEM_LAT, 1, memory access cycles per transfer (1..15).
- MAX_HOLD, 4, consecutive CPU grants allowed while DMA is waiting (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; held until cpu_done.
- cpu_wr  in  1  1=write, 0=read; valid with cpu_req.
- cpu_addr  in  AWIDTH  CPU address.
- cpu_wdata  in  DWIDTH  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted, operands latched.
- cpu_done  out  1  one-cycle pulse: CPU access complete.
- cpu_rdata  out  DWIDTH  CPU read data; valid from cpu_done until the next CPU read completes.
- dma_req, dma_wr, dma_addr, dma_wdata  in  same widths/meanings as the CPU signals, for the DMA port.
- dma_gnt, dma_done, dma_rdata  out  same widths/meanings as the CPU signals, for the DMA port.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DWIDTH  memory read data; valid in the last mem_rd cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=CPU, hold_cnt=0, lat_cnt=0.
  - All outputs 0: gnt, done, mem_rd, mem_wr, mem_addr, mem_wdata, both rdata, busy.
- Reset mid-access: the access is aborted immediately, no done pulse is issued, and the strobes drop asynchronously.
- State IDLE:
  - Sample requests each cycle.
  - Grant DMA if dma_req=1 and (cpu_req=0 or hold_cnt==MAX_HOLD).
  - Otherwise grant CPU if cpu_req=1.
  - On a grant: latch addr, wdata and wr into registers; record owner; pulse that owner's gnt in the next cycle; go to ACCESS.
  - With no request, stay in IDLE.
- State ACCESS:
  - mem_addr/mem_wdata come from the latched registers.
  - mem_rd = !wr_latched and mem_wr = wr_latched, both registered.
  - Strobe stays high for exactly MEM_LAT cycles (lat_cnt counts 0..MEM_LAT-1).
  - On the last cycle of a read, capture mem_rdata into the owner's rdata register.
  - After the last cycle, go to DONE.
- State DONE:
  - Owner's done=1 for one cycle; strobes are 0.
  - No arbitration in this cycle; next state is IDLE.
  - Requester must drop req in the cycle after done, or it is taken as a new request.
- Latency: req sampled high in IDLE at cycle N.
  - gnt at N+1, strobes at N+1 .. N+MEM_LAT.
  - done at N+MEM_LAT+1.
  - Earliest next grant at N+MEM_LAT+3.
- Hold counter:
  - Increments on each CPU grant made while dma_req=1, saturating at MAX_HOLD.
  - Clears on any DMA grant, and in IDLE whenever dma_req=0.
- Simultaneous requests: CPU wins unless hold_cnt==MAX_HOLD.
- A request deasserted before grant is never serviced; there is no queuing.
- Request changes after gnt have no effect on the access in flight.
- Writes leave rdata unchanged.
- Only the owner's gnt/done/rdata ever toggle; the other port's outputs hold.
- mem_addr/mem_wdata return to 0 in IDLE.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Owner encoding: OWN_CPU=1'b0, OWN_DMA=1'b1.
  - Default AWIDTH/DWIDTH.
- One sub-module: arb_hold_counter, the saturating starvation counter with inc/clr/at_max.
- FSM and datapath latches stay in the top module.

Test Plan:
- Reset: drive rst=0 with cpu_req=1 at t=0, release at t=30 -> all outputs 0 during reset; cpu_gnt one cycle after first sampled edge post-release.
- CPU read, MEM_LAT=1: cpu_addr=5'h03, memory holds 8'hA5 -> cpu_gnt at N+1, mem_rd=1 with mem_addr=03 at N+1 only, cpu_done at N+2 with cpu_rdata=8'hA5; dma outputs stay 0.
- DMA write: dma_addr=5'h1F, dma_wdata=8'h3C -> mem_wr=1 for one cycle with mem_addr=1F and mem_wdata=3C, dma_done next cycle; dma_rdata unchanged.
- Contention, MAX_HOLD=4: cpu_req and dma_req held high continuously -> grant order CPU,CPU,CPU,CPU,DMA,CPU,...; hold_cnt clears after the DMA grant.
- Reset mid-access, MEM_LAT=3: assert rst=0 during the second mem_rd cycle -> mem_rd drops immediately, no cpu_done, state IDLE, busy=0.
- Request withdrawn: cpu_req high for a cycle while the DMA access is in ACCESS, then low -> no CPU grant; arbiter returns to IDLE after dma_done and stays idle.
